// File: rtl/seg7_anim_multi_if.sv
// seg7_anim_multi_if: character handshake into the animated display.
// Carries a raw segment pattern and its apply mode.
interface seg7_anim_multi_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_seg;
  logic       in_mode;

  modport master (
    output in_valid,
    output in_seg,
    output in_mode,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_seg,
    input  in_mode,
    output in_ready
  );
endinterface

// File: rtl/seg7_anim_multi.sv
// seg7_anim_multi: FIFO-fed multi-digit 7-segment display with
// segment-by-segment wipe animation and multiplexed digit scan.
module seg7_anim_multi #(
  parameter int DIGITS     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_DIV  = 200000,
  parameter int SCAN_DIV   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  seg7_anim_multi_if.slave  in_if,
  input  logic              clr,
  output logic [6:0]        seg_out,
  output logic [DIGITS-1:0] dig_sel,
  output logic              busy
);

  localparam int DW = $clog2(DIGITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FRAME_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FRAME_DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    ANIM
  } state_t;

  state_t state_q, state_d;

  logic [7:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DIGITS-1:0][6:0] tgt_q, tgt_d;
  logic [DIGITS-1:0][6:0] disp_q, disp_d;
  logic [DW-1:0] cursor_q, cursor_d;
  logic [2:0]    step_q, step_d;

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [DW-1:0] idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic tick;
  logic [7:0] head;

  assign full  = (cnt_q == C_FULL);
  assign empty = (cnt_q == '0);
  assign in_if.in_ready = !full && !clr;
  assign push  = in_if.in_valid && in_if.in_ready;
  assign pop   = (state_q == IDLE) && !empty && !clr;
  assign head  = fifo_q[rp_q];
  assign tick  = ena && (fcnt_q == F_LAST);

  assign busy    = (state_q == ANIM);
  assign seg_out = seg_q;
  assign dig_sel = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;

  // Frame and scan dividers; both freeze while ena is low.
  always_comb begin
    fcnt_d = fcnt_q;
    scnt_d = scnt_q;
    idx_d  = idx_q;
    if (ena) begin
      fcnt_d = tick ? '0 : fcnt_q + 1'b1;
      if (scnt_q == S_LAST) begin
        scnt_d = '0;
        idx_d  = (idx_q == D_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; clear flushes everything.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pop into the target array, then wipe disp toward tgt one segment per frame.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    disp_d   = disp_q;
    cursor_d = cursor_q;
    step_d   = step_q;
    if (clr) begin
      tgt_d    = '0;
      cursor_d = '0;
      step_d   = '0;
      state_d  = ANIM;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            step_d  = '0;
            state_d = ANIM;
            if (head[7]) begin
              tgt_d[cursor_q] = head[6:0];
              cursor_d = (cursor_q == D_LAST) ? '0 : cursor_q + 1'b1;
            end else begin
              for (int d = 1; d < DIGITS; d++) begin
                tgt_d[d] = tgt_q[d-1];
              end
              tgt_d[0] = head[6:0];
            end
          end
        end
        ANIM: begin
          if (tick) begin
            for (int d = 0; d < DIGITS; d++) begin
              disp_d[d][step_q] = tgt_q[d][step_q];
            end
            step_d = step_q + 1'b1;
            if (step_q == 3'd6) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Segment register follows next-state disp/idx so it lines up with dig_sel.
  always_comb begin
    seg_d = disp_d[idx_d];
  end

  // FIFO storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= {in_if.in_mode, in_if.in_seg};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      tgt_q    <= '0;
      disp_q   <= '0;
      cursor_q <= '0;
      step_q   <= '0;
      fcnt_q   <= '0;
      scnt_q   <= '0;
      idx_q    <= '0;
      seg_q    <= '0;
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      disp_q   <= disp_d;
      cursor_q <= cursor_d;
      step_q   <= step_d;
      fcnt_q   <= fcnt_d;
      scnt_q   <= scnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
    end
  end

endmodule
